mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the processor's control strobes. It holds the memory address register (MAR), the memory data register (MDR) and a synchronous word RAM, and executes the one-cycle strobes issued by the control block: address latch, memory read, MDR load, memory write and bus drive. It sits between the shared datapath bus and main memory. A small sequencing FSM adds optional wait states and reports busy and error conditions.

## Interface
- DATA_W, 16, bus and memory word width
- ADDR_W, 8, address width; RAM depth is 2**ADDR_W
- WAIT_CYCLES, 0, extra wait cycles per RAM access (0..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- bus_in  in  DATA_W  shared datapath bus value
- wr_ma  in  1  latch bus_in[ADDR_W-1:0] into MAR
- re_ma  in  1  drive MAR, zero-extended, onto bus_out
- wr_md  in  1  latch bus_in into MDR
- re_md  in  1  drive MDR onto bus_out
- re_mem  in  1  start RAM read at MAR
- wr_md_mem  in  1  transfer read buffer into MDR
- wr_mem  in  1  start RAM write of MDR to MAR
- bus_out  out  DATA_W  data driven to the bus
- bus_oe  out  1  bus_out is valid
- mem_busy  out  1  RAM access in progress
- rd_valid  out  1  read buffer holds fresh data
- err  out  1  sticky protocol error
- par_err  out  1  sticky parity error (only with MEM_PARITY_EN)

## Operation
- Registers: MAR (ADDR_W), MDR (DATA_W) and rd_buf (DATA_W). All three reset to 0. RAM contents are not reset.
- FSM states: IDLE, RD_WAIT, WR_WAIT.
  - IDLE + re_mem: if WAIT_CYCLES=0, capture RAM[MAR] into rd_buf at that edge and stay in IDLE. Otherwise go to RD_WAIT, load wcnt=WAIT_CYCLES, and capture on the edge where wcnt reaches 0, then return to IDLE.
  - IDLE + wr_mem: same sequencing via WR_WAIT. RAM[MAR]<=MDR at the final edge.
- mem_busy=1 in RD_WAIT and WR_WAIT.
- The address and data for an access are sampled at start. MAR or MDR writes during the wait do not affect the access in flight.
- rd_valid: set on rd_buf capture. Cleared by wr_md_mem, wr_ma or a new access start.
- wr_md_mem: MDR<=rd_buf. If rd_valid=0, MDR is still loaded and err is set.
- wr_md has priority over wr_md_mem when both are asserted; err is set.
- bus_out (combinational):
  - re_md: bus_out = MDR.
  - else re_ma: bus_out = {0, MAR}.
  - else bus_out = 0.
  - bus_oe = re_md|re_ma.
  - If re_md and re_ma are both asserted, MDR wins and err is set.
- Errors (err is sticky, cleared only by rst):
  - re_mem and wr_mem asserted together: both are ignored and err is set.
  - re_mem or wr_mem asserted while mem_busy=1: the strobe is ignored and err is set.
- Address wrap: MAR takes only the low ADDR_W bits. The upper bus bits are discarded silently.

## Timing
- All register updates occur on the rising edge of clk. Strobes are sampled on the edge.
- Read latency with WAIT_CYCLES=0: re_mem sampled at edge k → rd_buf valid after edge k. wr_md_mem sampled at edge k+1 loads MDR. This matches the control sequence re_mem followed by wr_md_mem in the next cycle.
- General read or write latency: 1+WAIT_CYCLES edges from the start strobe.
- Reset values: bus_out=0, bus_oe=0, mem_busy=0, rd_valid=0, err=0, par_err=0. The FSM returns to IDLE.
- Reset during RD_WAIT or WR_WAIT aborts the access. A pending write is not performed.

## Configuration
- MEM_PARITY_EN:
  - Defined: each RAM word stores an extra even-parity bit, computed on write. On read capture the parity is checked; a mismatch sets the sticky par_err. rd_buf still loads the data.
  - Undefined: no parity storage, and par_err is tied to 0.

## Structure
- Shared package `mem_pkg`: FSM state encoding (IDLE, RD_WAIT, WR_WAIT) and the default DATA_W/ADDR_W constants.
- One sub-module, `mem_ram`: a single-port synchronous RAM with a registered read and an optional parity bit. The FSM, MAR, MDR and bus mux stay in mem_responder.

## Test plan
- WAIT_CYCLES=0 write/read:
  - Write path: wr_ma with bus=0x0012; wr_md with 0xBEEF; wr_mem → RAM[0x12]=0xBEEF after 1 edge.
  - Read back: wr_ma 0x0012; re_mem; wr_md_mem; re_md → bus_out=0xBEEF, bus_oe=1, err=0.
- Address wrap: wr_ma with bus=0x0F34 → re_ma drives 0x0034.
- WAIT_CYCLES=3:
  - re_mem → mem_busy=1 for 3 cycles; rd_valid asserts on the 4th edge.
  - A second re_mem during the busy window → ignored, err=1.
- Simultaneous re_mem and wr_mem → no RAM change, rd_valid unchanged, err=1.
- Reset mid-write: wr_mem with WAIT_CYCLES=3, rst on the 2nd cycle → RAM word unchanged; all outputs 0 after the next edge.
- MEM_PARITY_EN defined: force a flipped bit in the stored word, then re_mem → par_err=1 and rd_buf holds the corrupted data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared FSM encoding and default widths for the memory responder.
package mem_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/mem_ram.sv
// Single-port synchronous word RAM with registered read data (the read buffer).
// Optional even-parity bit per word when MEM_PARITY_EN is defined; par_bad flags a mismatch on a read.
module mem_ram
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_bad
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wdata;
  end

  // Contents are not reset; only the read buffer is.
  always_ff @(posedge clk) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

`ifdef MEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_mem[addr] <= ^wdata;
  end

  assign par_bad = rd_en & ((^mem[addr]) ^ par_mem[addr]);
`else
  assign par_bad = 1'b0;
`endif
endmodule

// File: rtl/mem_responder.sv
// MAR/MDR/RAM responder executing one-cycle control strobes, with optional wait states.
// Optional parity checking via MEM_PARITY_EN (par_err stays 0 without it).
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              wr_ma,
  input  logic              re_ma,
  input  logic              wr_md,
  input  logic              re_md,
  input  logic              re_mem,
  input  logic              wr_md_mem,
  input  logic              wr_mem,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              mem_busy,
  output logic              rd_valid,
  output logic              err,
  output logic              par_err
);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        wcnt;
  logic [ADDR_W-1:0] mar;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] acc_data;
  logic [DATA_W-1:0] rd_buf;
  logic              par_bad;

  logic start_rd, start_wr, last_edge, ram_rd, ram_wr, proto_err;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  assign mem_busy  = (state != IDLE);
  assign start_rd  = re_mem & ~wr_mem & ~mem_busy;
  assign start_wr  = wr_mem & ~re_mem & ~mem_busy;
  assign last_edge = mem_busy && (wcnt == 4'd1);

  // Zero wait states: the RAM is accessed on the start edge itself.
  assign ram_rd    = (WAIT_CYCLES == 0) ? start_rd : ((state == RD_WAIT) && last_edge);
  assign ram_wr    = ~rst & ((WAIT_CYCLES == 0) ? start_wr : ((state == WR_WAIT) && last_edge));
  assign ram_addr  = mem_busy ? acc_addr : mar;
  assign ram_wdata = mem_busy ? acc_data : mdr;

  assign proto_err = (re_mem & wr_mem)
                   | ((re_mem | wr_mem) & mem_busy)
                   | (wr_md_mem & ~rd_valid)
                   | (wr_md & wr_md_mem)
                   | (re_md & re_ma);

  always_comb begin
    bus_out = '0;
    if (re_md)      bus_out = mdr;
    else if (re_ma) bus_out = {{(DATA_W-ADDR_W){1'b0}}, mar};
  end
  assign bus_oe = re_md | re_ma;

  mem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .rd_en   (ram_rd),
    .wr_en   (ram_wr),
    .addr    (ram_addr),
    .wdata   (ram_wdata),
    .rdata   (rd_buf),
    .par_bad (par_bad)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wcnt     <= '0;
      mar      <= '0;
      mdr      <= '0;
      acc_addr <= '0;
      acc_data <= '0;
      rd_valid <= 1'b0;
      err      <= 1'b0;
      par_err  <= 1'b0;
    end else begin
      if (wr_ma) mar <= bus_in[ADDR_W-1:0];

      if (wr_md)          mdr <= bus_in;
      else if (wr_md_mem) mdr <= rd_buf;

      if (proto_err)        err     <= 1'b1;
      if (ram_rd & par_bad) par_err <= 1'b1;

      // A fresh capture outranks any clear on the same edge.
      if (ram_rd)
        rd_valid <= 1'b1;
      else if (wr_md_mem | wr_ma | start_rd | start_wr)
        rd_valid <= 1'b0;

      case (state)
        IDLE: begin
          if ((WAIT_CYCLES != 0) && (start_rd | start_wr)) begin
            state    <= start_rd ? RD_WAIT : WR_WAIT;
            wcnt     <= WC;
            acc_addr <= mar;
            acc_data <= mdr;
          end
        end
        RD_WAIT, WR_WAIT: begin
          wcnt <= wcnt - 4'd1;
          if (wcnt == 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboarded directed test of mem_responder with WAIT_CYCLES=0 and WAIT_CYCLES=3 instances.
module tb_mem_responder;
  localparam int WR_MA = 6, RE_MA = 5, WR_MD = 4, RE_MD = 3, RE_MEM = 2, WR_MDM = 1, WR_MEM = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bus_in = '0;
  logic [6:0]  strb = '0;
  logic        sel = 1'b0;
  logic        sample = 1'b0;
  logic [6:0]  s0, s3;

  always #5 clk = ~clk;

  assign s0 = sel ? 7'd0 : strb;
  assign s3 = sel ? strb : 7'd0;

  logic [15:0] d0_out, d3_out;
  logic d0_oe, d0_busy, d0_rdv, d0_err, d0_par;
  logic d3_oe, d3_busy, d3_rdv, d3_err, d3_par;

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .wr_ma(s0[WR_MA]), .re_ma(s0[RE_MA]), .wr_md(s0[WR_MD]), .re_md(s0[RE_MD]),
    .re_mem(s0[RE_MEM]), .wr_md_mem(s0[WR_MDM]), .wr_mem(s0[WR_MEM]),
    .bus_out(d0_out), .bus_oe(d0_oe), .mem_busy(d0_busy), .rd_valid(d0_rdv),
    .err(d0_err), .par_err(d0_par)
  );

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus_in(bus_in),
    .wr_ma(s3[WR_MA]), .re_ma(s3[RE_MA]), .wr_md(s3[WR_MD]), .re_md(s3[RE_MD]),
    .re_mem(s3[RE_MEM]), .wr_md_mem(s3[WR_MDM]), .wr_mem(s3[WR_MEM]),
    .bus_out(d3_out), .bus_oe(d3_oe), .mem_busy(d3_busy), .rd_valid(d3_rdv),
    .err(d3_err), .par_err(d3_par)
  );

  typedef struct packed {
    logic        sel;
    logic [15:0] out;
    logic        oe;
    logic        busy;
    logic        rdv;
    logic        err;
    logic        par;
  } exp_t;

  exp_t  eq[$];
  string tq[$];
  int    checks = 0;
  int    errors = 0;

  // Monitor: any probe or any bus drive must match the next expected record.
  always @(negedge clk) begin
    if (sample || d0_oe || d3_oe) begin
      if (eq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output d0_oe=%b d3_oe=%b with no expectation queued", d0_oe, d3_oe);
      end else begin
        exp_t  e;
        string t;
        logic [20:0] got, want;
        e = eq.pop_front();
        t = tq.pop_front();
        got  = e.sel ? {d3_out, d3_oe, d3_busy, d3_rdv, d3_err, d3_par}
                     : {d0_out, d0_oe, d0_busy, d0_rdv, d0_err, d0_par};
        want = {e.out, e.oe, e.busy, e.rdv, e.err, e.par};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s got out=%h oe=%b busy=%b rdv=%b err=%b par=%b expected out=%h oe=%b busy=%b rdv=%b err=%b par=%b",
                   t, got[20:5], got[4], got[3], got[2], got[1], got[0],
                   want[20:5], want[4], want[3], want[2], want[1], want[0]);
        end
      end
    end
  end

  // One edge with the given strobes applied.
  task automatic step(input logic [6:0] s, input logic [15:0] b);
    strb = s;
    bus_in = b;
    @(posedge clk);
    #1;
    strb = '0;
    bus_in = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(7'd0, 16'h0);
  endtask

  // Queue the expectation, present the strobes for the monitor, then let one edge pass.
  task automatic look(input logic [6:0] s, input string tag, input logic [15:0] out,
                      input logic oe, input logic busy, input logic rdv,
                      input logic e_err, input logic par);
    exp_t e;
    e = '{sel: sel, out: out, oe: oe, busy: busy, rdv: rdv, err: e_err, par: par};
    eq.push_back(e);
    tq.push_back(tag);
    strb = s;
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
    @(posedge clk);
    #1;
    strb = '0;
  endtask

  function automatic logic [6:0] b(input int i);
    logic [6:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    sel = 1'b0;
    look(7'd0, "reset0", 16'h0, 0, 0, 0, 0, 0);
    sel = 1'b1;
    look(7'd0, "reset3", 16'h0, 0, 0, 0, 0, 0);

    // Zero-wait-state instance
    sel = 1'b0;
    step(b(WR_MA), 16'h0012);
    step(b(WR_MD), 16'hBEEF);
    step(b(WR_MEM), 16'h0);
    step(b(WR_MD), 16'h0000);
    look(b(RE_MD), "mdr_cleared", 16'h0000, 1, 0, 0, 0, 0);
    step(b(WR_MA), 16'h0012);
    step(b(RE_MEM), 16'h0);
    look(7'd0, "rd_valid_w0", 16'h0, 0, 0, 1, 0, 0);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "readback_12", 16'hBEEF, 1, 0, 0, 0, 0);

    step(b(WR_MA), 16'h0F34);
    look(b(RE_MA), "addr_wrap", 16'h0034, 1, 0, 0, 0, 0);

    step(b(WR_MD), 16'h5A5A);
    step(b(WR_MEM), 16'h0);
    step(b(WR_MD), 16'h1111);
    step(b(RE_MEM), 16'h0);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "readback_34", 16'h5A5A, 1, 0, 0, 0, 0);

    step(b(WR_MA), 16'h0112);
    step(b(RE_MEM), 16'h0);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "readback_12_wrap", 16'hBEEF, 1, 0, 0, 0, 0);

    step(b(RE_MEM), 16'h0);
    step(b(WR_MD), 16'h7777);
    step(b(RE_MEM) | b(WR_MEM), 16'h0);
    look(7'd0, "clash", 16'h0, 0, 0, 1, 1, 0);
    step(b(RE_MEM), 16'h0);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "clash_ram_kept", 16'hBEEF, 1, 0, 0, 1, 0);
    look(b(RE_MD) | b(RE_MA), "md_wins", 16'hBEEF, 1, 0, 0, 1, 0);

`ifdef MEM_PARITY_EN
    step(b(WR_MA), 16'h0020);
    step(b(WR_MD), 16'h00F0);
    step(b(WR_MEM), 16'h0);
    u_dut0.u_ram.mem[8'h20] = 16'h00F1;
    step(b(RE_MEM), 16'h0);
    look(7'd0, "par_flag", 16'h0, 0, 0, 1, 1, 1);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "par_data", 16'h00F1, 1, 0, 0, 1, 1);
`endif

    // Three-wait-state instance
    sel = 1'b1;
    step(b(WR_MA), 16'h0012);
    step(b(WR_MD), 16'hCAFE);
    step(b(WR_MEM), 16'h0);
    look(7'd0, "wr_busy", 16'h0, 0, 1, 0, 0, 0);
    idle(3);
    step(b(WR_MD), 16'h0000);
    step(b(RE_MEM), 16'h0);
    look(7'd0, "rd_busy1", 16'h0, 0, 1, 0, 0, 0);
    look(7'd0, "rd_busy2", 16'h0, 0, 1, 0, 0, 0);
    look(7'd0, "rd_busy3", 16'h0, 0, 1, 0, 0, 0);
    look(7'd0, "rd_done", 16'h0, 0, 0, 1, 0, 0);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "rd3_data", 16'hCAFE, 1, 0, 0, 0, 0);

    step(b(RE_MEM), 16'h0);
    step(b(RE_MEM), 16'h0);
    look(7'd0, "busy_retrigger", 16'h0, 0, 1, 0, 1, 0);
    step(7'd0, 16'h0);
    look(7'd0, "retrigger_done", 16'h0, 0, 0, 1, 1, 0);

    // Reset in the middle of a wait-stated write
    step(b(WR_MD), 16'h0BAD);
    strb = b(WR_MEM);
    @(posedge clk);
    #1;
    strb = '0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    look(7'd0, "post_rst3", 16'h0, 0, 0, 0, 0, 0);
    sel = 1'b0;
    look(7'd0, "post_rst0", 16'h0, 0, 0, 0, 0, 0);
    sel = 1'b1;
    idle(4);
    step(b(WR_MA), 16'h0012);
    step(b(RE_MEM), 16'h0);
    idle(3);
    step(b(WR_MDM), 16'h0);
    look(b(RE_MD), "rst_abort_ram", 16'hCAFE, 1, 0, 0, 0, 0);

    idle(2);
    checks++;
    if (eq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", eq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
